// File: rtl/intdiv_pkg.sv
// Shared definitions for the integer-divide request controller: one-hot FSM
// encodings and the constants used to build divide-by-zero / overflow results.
package intdiv_pkg;

  localparam int FSM_W = 4;

  localparam int ST_IDLE_BIT  = 0;
  localparam int ST_ISSUE_BIT = 1;
  localparam int ST_WAIT_BIT  = 2;
  localparam int ST_RESP_BIT  = 3;

  typedef enum logic [FSM_W-1:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } state_e;

  localparam logic [31:0] ALL_ONES_32 = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN_32  = 32'h8000_0000;
  localparam logic [63:0] ALL_ONES_64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT_MIN_64  = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/intdiv_req_ctrl_if.sv
// Request, divider and response signals of the divide controller; the slave
// modport is the controller's view, master is the surrounding logic's view.
interface intdiv_req_ctrl_if #(
  parameter int D_W   = 32,
  parameter int TAG_W = 5
);
  logic             flush_i;

  logic             req_valid_i;
  logic             req_ready_o;
  logic [TAG_W-1:0] req_tag_i;
  logic             req_signed_i;
  logic             req_rem_i;
  logic [D_W-1:0]   req_dividend_i;
  logic [D_W-1:0]   req_divisor_i;

  logic             div_start_valid_o;
  logic             div_start_ready_i;
  logic             div_signed_op_o;
  logic [D_W-1:0]   div_dividend_o;
  logic [D_W-1:0]   div_divisor_o;
  logic             div_flush_o;

  logic             div_finish_valid_i;
  logic             div_finish_ready_o;
  logic [D_W-1:0]   div_quotient_i;
  logic [D_W-1:0]   div_remainder_i;
  logic             div_divisor_is_zero_i;

  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [TAG_W-1:0] rsp_tag_o;
  logic [D_W-1:0]   rsp_data_o;
  logic             rsp_bypass_o;

  modport slave (
    input  flush_i,
    input  req_valid_i, req_tag_i, req_signed_i, req_rem_i, req_dividend_i, req_divisor_i,
    output req_ready_o,
    output div_start_valid_o, div_signed_op_o, div_dividend_o, div_divisor_o, div_flush_o,
    input  div_start_ready_i,
    input  div_finish_valid_i, div_quotient_i, div_remainder_i, div_divisor_is_zero_i,
    output div_finish_ready_o,
    output rsp_valid_o, rsp_tag_o, rsp_data_o, rsp_bypass_o,
    input  rsp_ready_i
  );

  modport master (
    output flush_i,
    output req_valid_i, req_tag_i, req_signed_i, req_rem_i, req_dividend_i, req_divisor_i,
    input  req_ready_o,
    input  div_start_valid_o, div_signed_op_o, div_dividend_o, div_divisor_o, div_flush_o,
    output div_start_ready_i,
    output div_finish_valid_i, div_quotient_i, div_remainder_i, div_divisor_is_zero_i,
    input  div_finish_ready_o,
    input  rsp_valid_o, rsp_tag_o, rsp_data_o, rsp_bypass_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/intdiv_special_case_detect.sv
// Spots requests whose answer is fixed by definition (divide by zero, signed
// INT_MIN / -1) and produces that answer so the divider can be skipped.
module intdiv_special_case_detect
  import intdiv_pkg::*;
#(
  parameter int D_W = 32
) (
  input  logic           is_signed,
  input  logic [D_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  input  logic           rem,
  output logic           is_special,
  output logic [D_W-1:0] bypass_result
);
  localparam logic [D_W-1:0] ALL_ONES = (D_W == 64) ? D_W'(ALL_ONES_64) : D_W'(ALL_ONES_32);
  localparam logic [D_W-1:0] INT_MIN  = (D_W == 64) ? D_W'(INT_MIN_64)  : D_W'(INT_MIN_32);

  logic div_zero;
  logic overflow;

  assign div_zero = (divisor == '0);
  assign overflow = is_signed && (dividend == INT_MIN) && (divisor == ALL_ONES);

  assign is_special = div_zero | overflow;

  // Divide-by-zero wins: INT_MIN / 0 is still a zero divisor, not an overflow.
  always_comb begin
    bypass_result = '0;
    if (div_zero)      bypass_result = rem ? dividend : ALL_ONES;
    else if (overflow) bypass_result = rem ? '0 : dividend;
  end
endmodule

// File: rtl/intdiv_req_ctrl.sv
// Single-outstanding request controller in front of an iterative divider;
// trivial cases are answered locally, flush aborts whatever is in flight.
module intdiv_req_ctrl
  import intdiv_pkg::*;
#(
  parameter int D_W   = 32,
  parameter int TAG_W = 5
) (
  input logic               clk,
  input logic               rst_n,
  intdiv_req_ctrl_if.slave  bus
);
  state_e state_q, state_d;

  logic             flush;
  logic             req_ready, start_valid, finish_ready, rsp_valid;
  logic             accept, finish_hs;
  logic             is_special;
  logic [D_W-1:0]   bypass_result;

  logic [TAG_W-1:0] tag_q;
  logic             signed_q;
  logic             rem_q;
  logic [D_W-1:0]   dividend_q;
  logic [D_W-1:0]   divisor_q;
  logic [D_W-1:0]   result_q;
  logic             bypass_q;

  // The divider's own zero flag is redundant: zero divisors never reach it.
  logic unused_div_zero;
  assign unused_div_zero = bus.div_divisor_is_zero_i;

  assign flush = bus.flush_i;

  intdiv_special_case_detect #(.D_W(D_W)) u_special (
    .is_signed     (bus.req_signed_i),
    .dividend      (bus.req_dividend_i),
    .divisor       (bus.req_divisor_i),
    .rem           (bus.req_rem_i),
    .is_special    (is_special),
    .bypass_result (bypass_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    start_valid  = 1'b0;
    finish_ready = 1'b0;
    rsp_valid    = 1'b0;
    case (1'b1)
      state_q[ST_IDLE_BIT]: begin
        req_ready = ~flush;
        if (bus.req_valid_i && req_ready) state_d = is_special ? S_RESP : S_ISSUE;
      end
      state_q[ST_ISSUE_BIT]: begin
        start_valid = ~flush;
        if (start_valid && bus.div_start_ready_i) state_d = S_WAIT;
      end
      state_q[ST_WAIT_BIT]: begin
        finish_ready = ~flush;
        if (bus.div_finish_valid_i && finish_ready) state_d = S_RESP;
      end
      state_q[ST_RESP_BIT]: begin
        rsp_valid = ~flush;
        if (rsp_valid && bus.rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  assign accept    = req_ready & bus.req_valid_i;
  assign finish_hs = finish_ready & bus.div_finish_valid_i;

  // Payload registers carry no reset; their outputs are qualified by the FSM.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q      <= bus.req_tag_i;
      signed_q   <= bus.req_signed_i;
      rem_q      <= bus.req_rem_i;
      dividend_q <= bus.req_dividend_i;
      divisor_q  <= bus.req_divisor_i;
      result_q   <= bypass_result;
      bypass_q   <= is_special;
    end else if (finish_hs) begin
      result_q   <= rem_q ? bus.div_remainder_i : bus.div_quotient_i;
      bypass_q   <= 1'b0;
    end
  end

  assign bus.req_ready_o        = req_ready;
  assign bus.div_start_valid_o  = start_valid;
  assign bus.div_signed_op_o    = signed_q;
  assign bus.div_dividend_o     = dividend_q;
  assign bus.div_divisor_o      = divisor_q;
  assign bus.div_flush_o        = flush;
  assign bus.div_finish_ready_o = finish_ready;
  assign bus.rsp_valid_o        = rsp_valid;
  assign bus.rsp_tag_o          = tag_q;
  assign bus.rsp_data_o         = result_q;
  assign bus.rsp_bypass_o       = bypass_q;
endmodule

// File: tb/tb_intdiv_req_ctrl.sv
// Directed bench for intdiv_req_ctrl: divider path, bypass cases, stalls,
// flush interactions and asynchronous reset, with hand-computed expectations.
module tb_intdiv_req_ctrl;
  localparam int D_W   = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   start_seen = 0;
  int   start_mark;

  intdiv_req_ctrl_if #(.D_W(D_W), .TAG_W(TAG_W)) bus ();

  intdiv_req_ctrl #(.D_W(D_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.div_start_valid_o === 1'b1) start_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [TAG_W-1:0] tag, input logic sgn, input logic rem,
                         input logic [D_W-1:0] dvd, input logic [D_W-1:0] dvs);
    bus.req_valid_i    = 1'b1;
    bus.req_tag_i      = tag;
    bus.req_signed_i   = sgn;
    bus.req_rem_i      = rem;
    bus.req_dividend_i = dvd;
    bus.req_divisor_i  = dvs;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.flush_i = 0; bus.req_valid_i = 0; bus.req_tag_i = '0; bus.req_signed_i = 0;
    bus.req_rem_i = 0; bus.req_dividend_i = '0; bus.req_divisor_i = '0;
    bus.div_start_ready_i = 0; bus.div_finish_valid_i = 0; bus.div_quotient_i = '0;
    bus.div_remainder_i = '0; bus.div_divisor_is_zero_i = 0; bus.rsp_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    // reset state
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_start_valid", bus.div_start_valid_o, 0);
    chk("rst_finish_ready", bus.div_finish_ready_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_div_flush", bus.div_flush_o, 0);
    bus.flush_i = 1; #1;
    chk("flush_passthru", bus.div_flush_o, 1);
    chk("flush_gates_req_ready", bus.req_ready_o, 0);
    bus.flush_i = 0; #1;

    // unsigned 100 / 7 through the divider
    set_req(5'd5, 0, 0, 32'd100, 32'd7); #1;
    chk("t1_req_ready", bus.req_ready_o, 1);
    cyc();
    bus.req_valid_i = 0; #1;
    chk("t1_start_valid", bus.div_start_valid_o, 1);
    chk("t1_dividend", bus.div_dividend_o, 100);
    chk("t1_divisor", bus.div_divisor_o, 7);
    chk("t1_signed_op", bus.div_signed_op_o, 0);
    chk("t1_issue_req_ready", bus.req_ready_o, 0);
    bus.div_start_ready_i = 1;
    cyc();
    bus.div_start_ready_i = 0; #1;
    chk("t1_finish_ready", bus.div_finish_ready_o, 1);
    chk("t1_wait_start_low", bus.div_start_valid_o, 0);
    chk("t1_wait_rsp_low", bus.rsp_valid_o, 0);
    bus.div_finish_valid_i = 1; bus.div_quotient_i = 32'd14; bus.div_remainder_i = 32'd2;
    cyc();
    bus.div_finish_valid_i = 0; #1;
    chk("t1_rsp_valid", bus.rsp_valid_o, 1);
    chk("t1_rsp_data", bus.rsp_data_o, 14);
    chk("t1_rsp_bypass", bus.rsp_bypass_o, 0);
    chk("t1_rsp_tag", bus.rsp_tag_o, 5);
    chk("t1_resp_req_ready", bus.req_ready_o, 0);
    bus.rsp_ready_i = 1;
    cyc();
    bus.rsp_ready_i = 0; #1;
    chk("t1_done_rsp_valid", bus.rsp_valid_o, 0);
    chk("t1_done_req_ready", bus.req_ready_o, 1);

    // signed -100 % 7 with start and response stalls
    set_req(5'd3, 1, 1, 32'hFFFF_FF9C, 32'd7);
    cyc();
    bus.req_valid_i = 0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_start_valid", bus.div_start_valid_o, 1);
      chk("t2_stall_dividend", bus.div_dividend_o, 32'hFFFF_FF9C);
      chk("t2_stall_divisor", bus.div_divisor_o, 7);
      chk("t2_stall_signed", bus.div_signed_op_o, 1);
      cyc();
    end
    bus.div_start_ready_i = 1;
    cyc();
    bus.div_start_ready_i = 0;
    bus.div_finish_valid_i = 1; bus.div_quotient_i = 32'hFFFF_FFF2; bus.div_remainder_i = 32'hFFFF_FFFE;
    cyc();
    bus.div_finish_valid_i = 0; bus.div_quotient_i = '0; bus.div_remainder_i = '0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_rsp_valid", bus.rsp_valid_o, 1);
      chk("t2_hold_rsp_data", bus.rsp_data_o, 32'hFFFF_FFFE);
      chk("t2_hold_rsp_tag", bus.rsp_tag_o, 3);
      cyc();
    end
    bus.rsp_ready_i = 1;
    cyc();
    bus.rsp_ready_i = 0; #1;

    // signed overflow bypass, then back-to-back accept of its remainder form
    start_mark = start_seen;
    set_req(5'd7, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    cyc();
    bus.req_valid_i = 0; #1;
    chk("t3_ovf_rsp_valid", bus.rsp_valid_o, 1);
    chk("t3_ovf_q_data", bus.rsp_data_o, 32'h8000_0000);
    chk("t3_ovf_bypass", bus.rsp_bypass_o, 1);
    chk("t3_ovf_tag", bus.rsp_tag_o, 7);
    chk("t3_ovf_no_start", bus.div_start_valid_o, 0);
    bus.rsp_ready_i = 1;
    cyc();
    bus.rsp_ready_i = 0;
    set_req(5'd8, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF); #1;
    chk("t3_b2b_req_ready", bus.req_ready_o, 1);
    cyc();
    bus.req_valid_i = 0; #1;
    chk("t3_ovf_r_valid", bus.rsp_valid_o, 1);
    chk("t3_ovf_r_data", bus.rsp_data_o, 0);
    chk("t3_ovf_r_tag", bus.rsp_tag_o, 8);
    bus.rsp_ready_i = 1;
    cyc();
    bus.rsp_ready_i = 0;

    // divide by zero, quotient then remainder (signed variant for the latter)
    set_req(5'd9, 0, 0, 32'h1234_5678, 32'd0);
    cyc();
    bus.req_valid_i = 0; #1;
    chk("t4_dz_q_valid", bus.rsp_valid_o, 1);
    chk("t4_dz_q_data", bus.rsp_data_o, 32'hFFFF_FFFF);
    chk("t4_dz_q_bypass", bus.rsp_bypass_o, 1);
    bus.rsp_ready_i = 1;
    cyc();
    bus.rsp_ready_i = 0;
    set_req(5'd10, 1, 1, 32'h1234_5678, 32'd0);
    cyc();
    bus.req_valid_i = 0; #1;
    chk("t4_dz_r_valid", bus.rsp_valid_o, 1);
    chk("t4_dz_r_data", bus.rsp_data_o, 32'h1234_5678);
    chk("t4_dz_r_bypass", bus.rsp_bypass_o, 1);
    bus.rsp_ready_i = 1;
    cyc();
    bus.rsp_ready_i = 0; #1;
    chk("t4_bypass_never_started", start_seen, start_mark);

    // unsigned INT_MIN / all-ones is an ordinary divide; abort it in ISSUE
    set_req(5'd11, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    cyc();
    bus.req_valid_i = 0; #1;
    chk("t5_unsigned_issues", bus.div_start_valid_o, 1);
    chk("t5_unsigned_no_rsp", bus.rsp_valid_o, 0);
    bus.flush_i = 1; bus.div_start_ready_i = 1; #1;
    chk("t5_flush_gates_start", bus.div_start_valid_o, 0);
    cyc();
    bus.flush_i = 0; bus.div_start_ready_i = 0; #1;
    chk("t5_after_flush_ready", bus.req_ready_o, 1);

    // flush in WAIT, then a late finish is ignored
    set_req(5'd12, 0, 0, 32'd50, 32'd5);
    cyc();
    bus.req_valid_i = 0; bus.div_start_ready_i = 1;
    cyc();
    bus.div_start_ready_i = 0; #1;
    chk("t6_in_wait", bus.div_finish_ready_o, 1);
    bus.flush_i = 1; #1;
    chk("t6_flush_out", bus.div_flush_o, 1);
    chk("t6_flush_gates_finish", bus.div_finish_ready_o, 0);
    chk("t6_flush_gates_req", bus.req_ready_o, 0);
    cyc();
    bus.flush_i = 0; #1;
    chk("t6_post_req_ready", bus.req_ready_o, 1);
    chk("t6_post_div_flush", bus.div_flush_o, 0);
    bus.div_finish_valid_i = 1; bus.div_quotient_i = 32'd10; #1;
    chk("t6_late_finish_ignored", bus.div_finish_ready_o, 0);
    cyc();
    bus.div_finish_valid_i = 0; #1;
    chk("t6_no_rsp", bus.rsp_valid_o, 0);
    chk("t6_still_idle", bus.req_ready_o, 1);

    // flush coincident with a request, then with a response handshake
    set_req(5'd13, 0, 0, 32'd77, 32'd0);
    bus.flush_i = 1; #1;
    chk("t7_flush_blocks_accept", bus.req_ready_o, 0);
    cyc();
    bus.flush_i = 0; bus.req_valid_i = 0; #1;
    chk("t7_not_accepted_rsp", bus.rsp_valid_o, 0);
    chk("t7_not_accepted_idle", bus.req_ready_o, 1);
    set_req(5'd14, 0, 0, 32'd77, 32'd0);
    cyc();
    bus.req_valid_i = 0; #1;
    chk("t7_resp_up", bus.rsp_valid_o, 1);
    bus.rsp_ready_i = 1; bus.flush_i = 1; #1;
    chk("t7_flush_gates_rsp", bus.rsp_valid_o, 0);
    cyc();
    bus.rsp_ready_i = 0; bus.flush_i = 0; #1;
    chk("t7_rsp_dropped", bus.rsp_valid_o, 0);
    chk("t7_idle_after_drop", bus.req_ready_o, 1);

    // asynchronous reset mid-operation
    set_req(5'd15, 0, 0, 32'd9, 32'd3);
    cyc();
    bus.req_valid_i = 0; #1;
    chk("t8_issuing", bus.div_start_valid_o, 1);
    rst_n = 1'b0; #1;
    chk("t8_rst_start_low", bus.div_start_valid_o, 0);
    chk("t8_rst_req_ready", bus.req_ready_o, 1);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t8_no_rsp", bus.rsp_valid_o, 0);
    chk("t8_no_start", bus.div_start_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/intdiv_req_ctrl.md
INTDIV_REQ_CTRL -- requirements
Module: intdiv_req_ctrl

Interface
REQ-001 Parameter D_W, default 32, operand/result width; SHALL support 32 and 64.
REQ-002 Parameter TAG_W, default 5, request tag width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 flush_i  in  1  abort current operation.
REQ-006 req_valid_i / req_ready_o  in / out  1 / 1  request handshake.
REQ-007 req_tag_i  in  TAG_W; req_signed_i  in  1; req_rem_i  in  1 (1 = return remainder, 0 = quotient).
REQ-008 req_dividend_i, req_divisor_i  in  D_W  operands.
REQ-009 div_start_valid_o / div_start_ready_i  out / in  1  divider issue handshake.
REQ-010 div_signed_op_o  out  1; div_dividend_o, div_divisor_o  out  D_W; div_flush_o  out  1.
REQ-011 div_finish_valid_i / div_finish_ready_o  in / out  1  divider completion handshake.
REQ-012 div_quotient_i, div_remainder_i  in  D_W; div_divisor_is_zero_i  in  1 (ignored, see REQ-020).
REQ-013 rsp_valid_o / rsp_ready_i  out / in  1; rsp_tag_o  out  TAG_W; rsp_data_o  out  D_W; rsp_bypass_o  out  1 (result produced without divider).

Function
REQ-014 One-hot FSM, states IDLE, ISSUE, WAIT, RESP; at most one operation outstanding.
REQ-015 req_ready_o = IDLE & ~flush_i; on accept, tag/signed/rem/operands SHALL be registered.
REQ-016 IDLE accept, no special case -> ISSUE; special case -> RESP with bypass result, rsp_bypass_o=1.
REQ-017 ISSUE: div_start_valid_o = ~flush_i; div_signed_op_o/div_dividend_o/div_divisor_o driven from registers, stable until handshake; handshake -> WAIT.
REQ-018 WAIT: div_finish_ready_o = ~flush_i; on div_finish_valid_i capture req_rem ? div_remainder_i : div_quotient_i into result register -> RESP, rsp_bypass_o=0.
REQ-019 RESP: rsp_valid_o = ~flush_i; rsp_tag_o/rsp_data_o stable while valid; rsp_ready_i -> IDLE.
REQ-020 Divisor zero: quotient = all ones, remainder = dividend (both signed and unsigned); detected locally, divider never started.
REQ-021 Signed overflow (req_signed_i, dividend = 1<<(D_W-1), divisor = all ones): quotient = dividend, remainder = 0; divider never started.
REQ-022 Latency: bypass -> rsp_valid_o high the cycle after accept; divider path -> rsp_valid_o high the cycle after finish handshake.
REQ-023 flush_i: next state IDLE from any state; flush has priority over every handshake in same cycle (all valids/readies gated low); div_flush_o = flush_i combinationally; in-flight result discarded.
REQ-024 Flush on cycle N: req_ready_o high from cycle N+1.
REQ-025 rsp_ready_i held high in RESP: back-to-back accept possible in the IDLE cycle following; no combinational path rsp_ready_i -> req_ready_o.
REQ-026 div_finish_valid_i outside WAIT SHALL be ignored (div_finish_ready_o low).

Reset
REQ-027 Only FSM register reset (to IDLE); after reset req_ready_o=1, div_start_valid_o=0, div_finish_ready_o=0, rsp_valid_o=0, div_flush_o follows flush_i.
REQ-028 Data/tag/flag registers not reset; rsp_tag_o, rsp_data_o, rsp_bypass_o, div_* data outputs don't-care while corresponding valid is low.
REQ-029 Reset assertion mid-operation returns to IDLE immediately; no response emitted.

Structure
REQ-030 Shared package intdiv_pkg: FSM width/one-hot state encodings and state bit indices, special-result helper constants (all-ones, INT_MIN per D_W).
REQ-031 One combinational sub-module intdiv_special_case_detect: inputs signed, dividend, divisor, rem; outputs is_special, bypass_result.

Verification
REQ-032 D_W=32 unsigned 100/7, rem=0, divider returns q=14 -> rsp_data_o=14, rsp_bypass_o=0, tag echoed.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF, rem=0 -> rsp_data_o=0x80000000, bypass=1, div_start_valid_o never high; rem=1 -> 0.
REQ-034 Divisor 0, dividend 0x12345678: rem=0 -> 0xFFFFFFFF; rem=1 -> 0x12345678; valid cycle after accept.
REQ-035 div_start_ready_i low 5 cycles: div_start_valid_o and operands stable throughout; rsp_ready_i low 3 cycles: rsp outputs stable.
REQ-036 flush_i in WAIT, then late div_finish_valid_i: no response, div_flush_o pulsed, req_ready_o high next cycle.
REQ-037 flush_i coincident with req_valid_i and with rsp_ready_i: request not accepted, response dropped.
